// File: rtl/char_buffer_mmio.sv
// char_buffer_mmio: memory-mapped 64-cell text buffer feeding the VGA renderer.
// CPU stores inside the window update cells, a PUTC cursor, the cursor register,
// or start a hardware clear that blanks every cell, one cell per cycle.
//
// state | meaning
// IDLE  | accepting CPU stores
// CLEAR | blanking cell r_clr_idx each cycle, all stores dropped
module char_buffer_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          NUM_CHARS = 64,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MemWrite,
  input  logic [31:0]                  DataAdr,
  input  logic [31:0]                  WriteData,
  output logic [31:0]                  ReadData,
  output logic                         busy,
  output logic [$clog2(NUM_CHARS)-1:0] cursor,
  output logic [7:0]                   chars [NUM_CHARS]
);

  localparam int CW = $clog2(NUM_CHARS);

  localparam logic [6:0] OFF_PUTC   = 7'h40;
  localparam logic [6:0] OFF_CURSOR = 7'h41;
  localparam logic [6:0] OFF_CTRL   = 7'h42;
  localparam logic [6:0] OFF_STATUS = 7'h43;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        r_state;
  logic          r_busy;
  logic [CW-1:0] r_cursor;
  logic [CW-1:0] r_clr_idx;
  logic [7:0]    r_chars [NUM_CHARS];

  logic          w_hit;
  logic [6:0]    w_off;
  logic          w_cell;
  logic [CW-1:0] w_idx;
  logic          w_we;
  logic          w_unused;

  assign w_hit    = (DataAdr[31:9] == BASE_ADDR[31:9]);
  assign w_off    = DataAdr[8:2];
  // Cell region is offsets 0..63; only indices below NUM_CHARS are backed.
  assign w_cell   = ~w_off[6] && ({1'b0, w_off[5:0]} < 7'(NUM_CHARS));
  assign w_idx    = w_off[CW-1:0];
  // Stores are ignored entirely while a clear is running.
  assign w_we     = MemWrite && w_hit && !r_busy;
  assign w_unused = ^{DataAdr[1:0], WriteData[31:8], w_off[5:0]};

  assign busy   = r_busy;
  assign cursor = r_cursor;
  assign chars  = r_chars;

  // Readback mux: cell contents, cursor, and status; everything else reads 0.
  always_comb begin
    ReadData = 32'h0;
    if (w_hit) begin
      if (w_cell)
        ReadData = {24'h0, r_chars[w_idx]};
      else if (w_off == OFF_CURSOR)
        ReadData = 32'(r_cursor);
      else if (w_off == OFF_STATUS)
        ReadData = {31'h0, r_busy};
    end
  end

  // Store decode and clear sequencer; reset overrides any same-cycle store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) r_chars[i] <= BLANK;
      r_cursor  <= '0;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
      r_state   <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_we) begin
            if (w_cell) begin
              r_chars[w_idx] <= WriteData[7:0];
            end else if (w_off == OFF_PUTC) begin
              r_chars[r_cursor] <= WriteData[7:0];
              // NUM_CHARS is a power of two, so the natural wrap is the required one.
              r_cursor <= r_cursor + 1'b1;
            end else if (w_off == OFF_CURSOR) begin
              r_cursor <= WriteData[CW-1:0];
            end else if (w_off == OFF_CTRL && WriteData[0]) begin
              r_clr_idx <= '0;
              r_busy    <= 1'b1;
              r_state   <= CLEAR;
            end
          end
        end
        CLEAR: begin
          r_chars[r_clr_idx] <= BLANK;
          if (r_clr_idx == CW'(NUM_CHARS - 1)) begin
            r_clr_idx <= '0;
            r_cursor  <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
